mux_scan_sequencer: RTL and testbench
=====================================

// Module: mux_scan_sequencer
// PURPOSE
//  Drives the 2-bit channel select of the 4:1 multiplexer and samples its single-bit output once per channel.
//  It sweeps channels 0..3, waiting a settle delay after each select change before sampling.
//  The four samples are packed into a 4-bit word, which is offered downstream with a valid/ready handshake.
//  Sits around the mux: sel feeds the mux select C, and mux_y takes the mux output Y.
// PARAMETERS
//  SETTLE_CYCLES  1  clocks to hold sel stable before sampling mux_y; legal range 1..15
// PORTS
//  clk         in   1  single clock, rising edge
//  rst_n       in   1  asynchronous reset, active low
//  start       in   1  begin a scan; sampled only in IDLE
//  cont        in   1  continuous mode; sampled at each word handshake
//  mux_y       in   1  mux output for the currently selected channel
//  sel         out  2  channel select to the mux
//  word        out  4  packed samples; word[i] is the sample from channel i
//  word_valid  out  1  word is available
//  word_ready  in   1  downstream accepts word
//  busy        out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous, takes effect immediately, including mid-scan):
//   state=IDLE, sel=0, word=0, word_valid=0, busy=0, settle counter=0, shift register=0.
//  FSM states: IDLE, SETTLE, SAMPLE, OUTPUT.
//   IDLE:
//    - start=1 -> SETTLE; sel=0; counter=SETTLE_CYCLES-1.
//    - Otherwise stay in IDLE.
//   SETTLE:
//    - Decrement the counter each clock.
//    - When counter=0 -> SAMPLE. SETTLE therefore lasts exactly SETTLE_CYCLES clocks.
//   SAMPLE (1 clock):
//    - Capture mux_y into shift register bit[sel].
//    - If sel<3: sel=sel+1, counter reloaded, -> SETTLE.
//    - If sel=3: word is loaded with the completed 4-bit value (including this final bit), word_valid=1 -> OUTPUT.
//   OUTPUT:
//    - Hold word and word_valid stable while word_ready=0.
//    - On word_valid&word_ready at a clock edge:
//      - cont=1: clear word_valid, sel=0, counter reloaded, -> SETTLE.
//      - cont=0: clear word_valid -> IDLE.
//  Timing rules:
//   - sel changes only on the clock edge that enters SETTLE, never within SETTLE or SAMPLE.
//   - With start sampled at edge k, channel i is captured at edge k+(i+1)(SETTLE_CYCLES+1).
//   - word_valid rises at edge k+4(SETTLE_CYCLES+1); this is 8 edges for the default setting.
//  Boundary conditions:
//   - start while busy is ignored; no restart and no error.
//   - cont changes mid-scan have no effect until the handshake.
//   - word_ready asserted outside OUTPUT is ignored.
//   - A handshake that completes and a new start in the same cycle: start is ignored, because the FSM is not yet IDLE.
//   - sel wraps 3->0 only through the OUTPUT->SETTLE path.
//   - The shift register is not cleared between scans; every bit is overwritten each scan.
//   - mux_y is sampled directly; the upstream mux is combinational on the same clock domain.
// CONFIGURATION
//  Macro MUX_SCAN_PARITY_EN:
//   - Defined: adds output port word_par (1 bit).
//     - word_par = ^word, registered in the same edge as word.
//     - Reset value 0; held stable with word while word_valid=1.
//   - Undefined: port word_par and its logic are absent. All other behaviour is identical.
// TESTING
//  1 Reset: assert rst_n=0 mid-SETTLE with sel=2 -> sel=0, word_valid=0, busy=0 immediately, without waiting for clk.
//  2 Single scan: SETTLE_CYCLES=1, mux inputs X=4'b1010, start pulse, word_ready=1
//    -> sel steps 0,1,2,3 every 2 clocks; word=4'b1010 with word_valid high 8 edges after start; then IDLE.
//  3 Backpressure: word_ready=0 for 5 clocks after word_valid
//    -> word/word_valid stable for all 5 clocks; accepted on the first ready=1 edge; busy drops the next cycle.
//  4 Continuous: cont=1, X changes 4'b0001 -> 4'b1110 between scans
//    -> consecutive words 4'b0001 and 4'b1110; sel returns to 0 right after the handshake, with no IDLE cycle.
//  5 Start ignored: pulse start at cycles 2 and 5 of a scan -> exactly one word produced; timing unchanged.
//  6 Parity (MUX_SCAN_PARITY_EN): X=4'b0111 -> word_par=1; X=4'b0110 -> word_par=0.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// Sweeps a 4:1 mux select, samples each channel after a settle delay and offers the packed word via valid/ready.
// Optional MUX_SCAN_PARITY_EN adds a registered even-parity output word_par alongside word.
module mux_scan_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       mux_y,
  output logic [1:0] sel,
  output logic [3:0] word,
  output logic       word_valid,
  input  logic       word_ready,
  output logic       busy
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic       word_par
`endif
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, OUTPUT} state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_n;
  logic [1:0] sel_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] shift, shift_n;
  logic [3:0] word_n;
  logic       valid_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= 2'd0;
      cnt        <= 4'd0;
      shift      <= 4'd0;
      word       <= 4'd0;
      word_valid <= 1'b0;
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      cnt        <= cnt_n;
      shift      <= shift_n;
      word       <= word_n;
      word_valid <= valid_n;
    end
  end

  // The final sample is merged into the word in the same edge it is captured.
  always_comb begin
    state_n = state;
    sel_n   = sel;
    cnt_n   = cnt;
    shift_n = shift;
    word_n  = word;
    valid_n = word_valid;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SETTLE;
          sel_n   = 2'd0;
          cnt_n   = RELOAD;
        end
      end
      SETTLE: begin
        if (cnt == 4'd0) state_n = SAMPLE;
        else             cnt_n   = cnt - 4'd1;
      end
      SAMPLE: begin
        shift_n[sel] = mux_y;
        if (sel != 2'd3) begin
          sel_n   = sel + 2'd1;
          cnt_n   = RELOAD;
          state_n = SETTLE;
        end else begin
          word_n  = shift_n;
          valid_n = 1'b1;
          state_n = OUTPUT;
        end
      end
      OUTPUT: begin
        if (word_ready) begin
          valid_n = 1'b0;
          if (cont) begin
            sel_n   = 2'd0;
            cnt_n   = RELOAD;
            state_n = SETTLE;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

`ifdef MUX_SCAN_PARITY_EN
  // word_n equals word whenever no new word is loaded, so parity tracks word exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) word_par <= 1'b0;
    else        word_par <= ^word_n;
  end
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer: directed scenarios plus randomized traffic against a scan-timeline model.
module tb_mux_scan_sequencer;

  localparam int S = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       word_ready = 1'b0;
  logic [3:0] x = 4'd0;
  logic       mux_y;
  logic [1:0] sel;
  logic [3:0] word;
  logic       word_valid;
  logic       busy;
`ifdef MUX_SCAN_PARITY_EN
  logic       word_par;
`endif

  int compared = 0;
  int mismatched = 0;
  int words = 0;
  bit check_en = 1'b0;

  // Reference model: position in the scan timeline, counted in edges since the scan began.
  bit         m_busy = 1'b0;
  bit         m_out = 1'b0;
  int         m_t = 0;
  logic [3:0] m_samp = 4'd0;
  logic [3:0] m_word = 4'd0;
  int         m_last_sel = 0;

  assign mux_y = x[sel];

  always #5 clk = ~clk;

  mux_scan_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cont       (cont),
    .mux_y      (mux_y),
    .sel        (sel),
    .word       (word),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy)
`ifdef MUX_SCAN_PARITY_EN
    ,
    .word_par   (word_par)
`endif
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Channel i is captured (i+1)*(S+1) edges after the scan starts; the word appears with channel 3.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_out = 1'b0; m_t = 0; m_word = 4'd0; m_last_sel = 0;
    end else if (!m_busy) begin
      if (start) begin m_busy = 1'b1; m_t = 0; end
    end else if (m_out) begin
      if (word_ready) begin
        m_out = 1'b0;
        if (cont) m_t = 0;
        else begin m_busy = 1'b0; m_last_sel = 3; end
      end
    end else begin
      m_t++;
      if (m_t % (S + 1) == 0) begin
        int ch;
        ch = m_t / (S + 1) - 1;
        m_samp[ch] = x[ch];
        if (ch == 3) begin m_out = 1'b1; m_word = m_samp; end
      end
    end
  end

  always @(posedge clk) if (rst_n && word_valid && word_ready) words++;

  always @(negedge clk) begin
    if (check_en) begin
      int exp_sel;
      exp_sel = !m_busy ? m_last_sel : (m_out ? 3 : m_t / (S + 1));
      checkOutput("sel", int'(sel), exp_sel);
      checkOutput("busy", int'(busy), int'(m_busy));
      checkOutput("word_valid", int'(word_valid), int'(m_out));
      checkOutput("word", int'(word), int'(m_word));
`ifdef MUX_SCAN_PARITY_EN
      checkOutput("word_par", int'(word_par), int'(^m_word));
`endif
    end
  end

  task automatic applyStimulus(input bit s, input bit r, input bit c, input logic [3:0] xv);
    start = s; word_ready = r; cont = c; x = xv;
  endtask

  task automatic startScan(input logic [3:0] xv);
    x = xv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitValid(output int n);
    n = 0;
    while (word_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (word_valid !== 1'b1) checkOutput("valid_timeout", 0, 1);
  endtask

  task automatic accept();
    word_ready = 1'b1;
    @(posedge clk); #1;
    word_ready = 1'b0;
  endtask

  initial begin
    int n;
    int words0;
    check_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_sel", int'(sel), 0);
    checkOutput("rst_word", int'(word), 0);
    checkOutput("rst_valid", int'(word_valid), 0);
    checkOutput("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of the channel-2 settle window
    startScan(4'b1100);
    repeat (4) @(posedge clk);
    #3;
    checkOutput("pre_rst_sel", int'(sel), 2);
    rst_n = 1'b0;
    #1;
    checkOutput("async_sel", int'(sel), 0);
    checkOutput("async_valid", int'(word_valid), 0);
    checkOutput("async_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single scan with immediate acceptance
    word_ready = 1'b1;
    startScan(4'b1010);
    waitValid(n);
    checkOutput("single_latency", n, 8);
    checkOutput("single_word", int'(word), 4'b1010);
    @(posedge clk); #1;
    checkOutput("single_idle_busy", int'(busy), 0);
    checkOutput("single_idle_sel", int'(sel), 3);
    word_ready = 1'b0;

    // Backpressure holds the word for five clocks
    startScan(4'b0110);
    waitValid(n);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_word", int'(word), 4'b0110);
      checkOutput("bp_valid", int'(word_valid), 1);
    end
    word_ready = 1'b1;
    @(posedge clk); #1;
    word_ready = 1'b0;
    checkOutput("bp_valid_drop", int'(word_valid), 0);
    checkOutput("bp_busy_drop", int'(busy), 0);

    // Continuous mode restarts straight from the handshake
    cont = 1'b1;
    startScan(4'b0001);
    waitValid(n);
    checkOutput("cont_word0", int'(word), 4'b0001);
    x = 4'b1110;
    word_ready = 1'b1;
    @(posedge clk); #1;
    word_ready = 1'b0; cont = 1'b0;
    checkOutput("cont_valid_drop", int'(word_valid), 0);
    checkOutput("cont_sel_wrap", int'(sel), 0);
    checkOutput("cont_busy", int'(busy), 1);
    waitValid(n);
    checkOutput("cont_latency", n, 8);
    checkOutput("cont_word1", int'(word), 4'b1110);
    accept();
    checkOutput("cont_end_busy", int'(busy), 0);

    // Extra start pulses during a scan are ignored
    words0 = words;
    word_ready = 1'b1;
    startScan(4'b0101);
    n = 0;
    while (word_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
      start = (n == 1 || n == 4);
    end
    start = 1'b0;
    checkOutput("ign_latency", n, 8);
    checkOutput("ign_word", int'(word), 4'b0101);
    repeat (12) @(posedge clk);
    #1;
    checkOutput("ign_word_count", words - words0, 1);
    checkOutput("ign_busy", int'(busy), 0);
    word_ready = 1'b0;

`ifdef MUX_SCAN_PARITY_EN
    startScan(4'b0111);
    waitValid(n);
    checkOutput("par_odd", int'(word_par), 1);
    accept();
    startScan(4'b0110);
    waitValid(n);
    checkOutput("par_even", int'(word_par), 0);
    accept();
`endif

    // Randomized traffic, compared every cycle against the model
    repeat (400) begin
      @(negedge clk);
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 3) == 0) ? 4'($urandom) : x);
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, x);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("final_idle", int'(busy), 0);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
